// File: rtl/arr_mult_pipe.sv
// Pipelined WIDTH x WIDTH array multiplier: carry-save rows of full-adder cells, ripple final adder,
// STAGES register stages with valid/ready handshakes and full-pipeline stall on back-pressure.
module arr_mult_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int PW = 2 * WIDTH;

  // Baugh-Wooley correction: +1 at column WIDTH and +1 at column 2*WIDTH-1.
  localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  typedef struct packed {
    logic             valid;
    logic             sgn;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [PW-1:0]    sum;
    logic [PW-1:0]    carry;
  } stage_t;

  stage_t stg_q [STAGES];
  stage_t src   [STAGES];
  stage_t stg_d [STAGES];
  logic   en;

  // First array row handled by stage s; stage s covers rows row_lo(s) .. row_lo(s+1)-1.
  function automatic int row_lo(input int s);
    return (s * WIDTH) / STAGES;
  endfunction

  // One row of full-adder cells folding partial product a & {WIDTH{b[row]}} into sum/carry.
  function automatic stage_t csa_row(input stage_t st, input int row);
    logic [PW-1:0] pp;
    logic [PW-1:0] maj;
    logic          pp_bit;
    stage_t        r;
    pp = '0;
    for (int j = 0; j < WIDTH; j++) begin
      pp_bit = st.op_a[j] & st.op_b[row];
      if (st.sgn && ((j == WIDTH - 1) != (row == WIDTH - 1))) pp_bit = ~pp_bit;
      pp[row + j] = pp_bit;
    end
    maj     = (st.sum & st.carry) | (st.sum & pp) | (st.carry & pp);
    r       = st;
    r.sum   = st.sum ^ st.carry ^ pp;
    r.carry = {maj[PW-2:0], 1'b0};
    return r;
  endfunction

  // Ripple adder resolving the carry-save pair; carry out of the top bit is discarded.
  function automatic logic [PW-1:0] ripple_add(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic [PW-1:0] res;
    logic          c;
    c = 1'b0;
    for (int i = 0; i < PW; i++) begin
      res[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return res;
  endfunction

  assign en        = !stg_q[STAGES-1].valid || out_ready;
  assign in_ready  = en;
  assign out_valid = stg_q[STAGES-1].valid;
  assign p         = stg_q[STAGES-1].sum;

  // NOTE: every element is assigned on every pass through the block, so no latch is inferred.
  always_comb begin
    src[0]       = '0;
    src[0].valid = in_valid;
    src[0].sgn   = is_signed;
    src[0].op_a  = a;
    src[0].op_b  = b;
    src[0].sum   = is_signed ? BW_CONST : '0;
    for (int s = 1; s < STAGES; s++) src[s] = stg_q[s-1];
  end

  always_comb begin
    stage_t cur;
    for (int s = 0; s < STAGES; s++) begin
      cur = src[s];
      for (int r = 0; r < WIDTH; r++) begin
        if (r >= row_lo(s) && r < row_lo(s + 1)) cur = csa_row(cur, r);
      end
      if (s == STAGES - 1) begin
        cur.sum   = ripple_add(cur.sum, cur.carry);
        cur.carry = '0;
      end
      stg_d[s] = cur;
    end
  end

  // NOTE: the stage array is a set of pipeline registers, not a RAM, so it is reset along with the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) stg_q[s] <= '0;
    end else if (en) begin
      for (int s = 0; s < STAGES; s++) stg_q[s] <= stg_d[s];
    end
  end

endmodule
